// File: rtl/wb_uart.sv
// Wishbone classic UART: programmable baud divisor, TX holding + shifter,
// RX synchroniser with mid-bit sampling, small RX FIFO and sticky error flags.
module wb_uart #(
    parameter int unsigned DATABITS = 8,
    parameter int unsigned DIVWIDTH = 16,
    parameter int unsigned DEFDIV   = 104,
    parameter int unsigned RXAW     = 2
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        STB_I,
    input  logic        WE_I,
    input  logic [1:0]  ADR_I,
    input  logic [31:0] DAT_I,
    output logic [31:0] DAT_O,
    output logic        ACK_O,
    input  logic        usartRX,
    output logic        usartTX,
    output logic        irq
);

    localparam int unsigned BW    = (DATABITS > 1) ? $clog2(DATABITS) : 1;
    localparam int unsigned DEPTH = 1 << RXAW;
    localparam logic [DIVWIDTH-1:0] ONE    = DIVWIDTH'(1);
    localparam logic [DIVWIDTH-1:0] MINDIV = DIVWIDTH'(4);
    localparam logic [BW-1:0]       LASTBIT = BW'(DATABITS - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    logic [DIVWIDTH-1:0] r_div;
    logic                r_rxie, r_txie;
    logic                r_rxovr, r_ferr, r_txovr;

    tx_state_t           r_tx_state;
    logic [DIVWIDTH-1:0] r_tx_cnt;
    logic [BW-1:0]       r_tx_bits;
    logic [DATABITS-1:0] r_tx_sh;
    logic [DATABITS-1:0] r_thr;
    logic                r_thr_full;
    logic                r_tx;

    rx_state_t           r_rx_state;
    logic                r_rx_s1, r_rx_s2, r_rx_s3;
    logic [DIVWIDTH-1:0] r_rx_cnt;
    logic [BW-1:0]       r_rx_bits;
    logic [DATABITS-1:0] r_rx_sh;
    logic [DATABITS-1:0] r_rx_byte;
    logic                r_rx_push;
    logic                r_rx_ferr;

    logic [DATABITS-1:0] r_mem [DEPTH];
    logic [RXAW:0]       r_wp, r_rp;

    logic                w_rd, w_wr;
    logic                w_wr_data, w_wr_stat, w_wr_div, w_wr_ctrl, w_rd_data;
    logic                w_flush, w_empty, w_full, w_pop, w_push_ok, w_rx_overrun;
    logic                w_txidle;
    logic [DIVWIDTH-1:0] w_div_wr;
    logic [31:0]         w_rdata;
    logic                w_unused;

    assign ACK_O   = STB_I;
    assign usartTX = r_tx;

    assign w_rd      = STB_I & ~WE_I;
    assign w_wr      = STB_I & WE_I;
    assign w_wr_data = w_wr & (ADR_I == 2'd0);
    assign w_wr_stat = w_wr & (ADR_I == 2'd1);
    assign w_wr_div  = w_wr & (ADR_I == 2'd2);
    assign w_wr_ctrl = w_wr & (ADR_I == 2'd3);
    assign w_rd_data = w_rd & (ADR_I == 2'd0);
    assign w_flush   = w_wr_ctrl & DAT_I[2];

    assign w_empty = (r_wp == r_rp);
    assign w_full  = (r_wp[RXAW] != r_rp[RXAW]) && (r_wp[RXAW-1:0] == r_rp[RXAW-1:0]);
    assign w_pop   = w_rd_data & ~w_empty;
    // A pop in the same cycle frees the slot, so a store into a full FIFO still lands.
    assign w_push_ok    = r_rx_push & (~w_full | w_pop) & ~w_flush;
    assign w_rx_overrun = r_rx_push & w_full & ~w_pop;

    assign w_txidle = ~r_thr_full & (r_tx_state == TX_IDLE);
    assign w_div_wr = (DAT_I[DIVWIDTH-1:0] < MINDIV) ? MINDIV : DAT_I[DIVWIDTH-1:0];
    assign irq      = (~w_empty & r_rxie) | (~r_thr_full & r_txie);
    assign w_unused = ^DAT_I;

    always_comb begin
        w_rdata = '0;
        case (ADR_I)
            2'd0: if (!w_empty) begin
                w_rdata[31]            = 1'b1;
                w_rdata[DATABITS-1:0]  = r_mem[r_rp[RXAW-1:0]];
            end
            2'd1: w_rdata[5:0] = {r_txovr, r_ferr, r_rxovr, w_txidle, ~r_thr_full, ~w_empty};
            2'd2: w_rdata[DIVWIDTH-1:0] = r_div;
            default: w_rdata[1:0] = {r_txie, r_rxie};
        endcase
    end

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            DAT_O   <= '0;
            r_div   <= DIVWIDTH'(DEFDIV);
            r_rxie  <= 1'b0;
            r_txie  <= 1'b0;
            r_rxovr <= 1'b0;
            r_ferr  <= 1'b0;
            r_txovr <= 1'b0;
            r_wp    <= '0;
            r_rp    <= '0;
        end else begin
            if (w_rd)
                DAT_O <= w_rdata;
            if (w_wr_div)
                r_div <= w_div_wr;
            if (w_wr_ctrl) begin
                r_rxie <= DAT_I[0];
                r_txie <= DAT_I[1];
            end
            // New error events win over a simultaneous write-1-to-clear.
            r_rxovr <= (r_rxovr & ~(w_wr_stat & DAT_I[3])) | w_rx_overrun;
            r_ferr  <= (r_ferr  & ~(w_wr_stat & DAT_I[4])) | r_rx_ferr;
            r_txovr <= (r_txovr & ~(w_wr_stat & DAT_I[5])) | (w_wr_data & r_thr_full);
            if (w_flush)
                r_rp <= r_wp;
            else if (w_pop)
                r_rp <= r_rp + 1'b1;
            if (w_push_ok)
                r_wp <= r_wp + 1'b1;
        end
    end

    always_ff @(posedge CLK_I) begin
        if (w_push_ok)
            r_mem[r_wp[RXAW-1:0]] <= r_rx_byte;
    end

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bits  <= '0;
            r_tx_sh    <= '0;
            r_thr      <= '0;
            r_thr_full <= 1'b0;
            r_tx       <= 1'b1;
        end else begin
            if (w_wr_data && !r_thr_full) begin
                r_thr      <= DAT_I[DATABITS-1:0];
                r_thr_full <= 1'b1;
            end
            case (r_tx_state)
                TX_IDLE: begin
                    if (r_thr_full) begin
                        r_tx_sh    <= r_thr;
                        r_thr_full <= 1'b0;
                        r_tx       <= 1'b0;
                        r_tx_cnt   <= r_div - ONE;
                        r_tx_state <= TX_START;
                    end
                end
                default: begin
                    if (r_tx_cnt != '0) begin
                        r_tx_cnt <= r_tx_cnt - ONE;
                    end else begin
                        // Reloading from r_div here makes a mid-frame DIV write apply at the next bit.
                        r_tx_cnt <= r_div - ONE;
                        case (r_tx_state)
                            TX_START: begin
                                r_tx       <= r_tx_sh[0];
                                r_tx_bits  <= '0;
                                r_tx_state <= TX_DATA;
                            end
                            TX_DATA: begin
                                if (r_tx_bits == LASTBIT) begin
                                    r_tx       <= 1'b1;
                                    r_tx_state <= TX_STOP;
                                end else begin
                                    r_tx_sh   <= r_tx_sh >> 1;
                                    r_tx      <= r_tx_sh[1];
                                    r_tx_bits <= r_tx_bits + BW'(1);
                                end
                            end
                            default: begin
                                if (r_thr_full) begin
                                    r_tx_sh    <= r_thr;
                                    r_thr_full <= 1'b0;
                                    r_tx       <= 1'b0;
                                    r_tx_state <= TX_START;
                                end else begin
                                    r_tx_state <= TX_IDLE;
                                end
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_s3    <= 1'b1;
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bits  <= '0;
            r_rx_sh    <= '0;
            r_rx_byte  <= '0;
            r_rx_push  <= 1'b0;
            r_rx_ferr  <= 1'b0;
        end else begin
            r_rx_s1   <= usartRX;
            r_rx_s2   <= r_rx_s1;
            r_rx_s3   <= r_rx_s2;
            r_rx_push <= 1'b0;
            r_rx_ferr <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    if (r_rx_s3 && !r_rx_s2) begin
                        r_rx_cnt   <= (r_div >> 1) - ONE;
                        r_rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (r_rx_cnt != '0) begin
                        r_rx_cnt <= r_rx_cnt - ONE;
                    end else if (r_rx_s2) begin
                        r_rx_state <= RX_IDLE;
                    end else begin
                        r_rx_cnt   <= r_div - ONE;
                        r_rx_bits  <= '0;
                        r_rx_state <= RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (r_rx_cnt != '0) begin
                        r_rx_cnt <= r_rx_cnt - ONE;
                    end else begin
                        r_rx_cnt <= r_div - ONE;
                        r_rx_sh  <= {r_rx_s2, r_rx_sh[DATABITS-1:1]};
                        if (r_rx_bits == LASTBIT)
                            r_rx_state <= RX_STOP;
                        else
                            r_rx_bits <= r_rx_bits + BW'(1);
                    end
                end
                default: begin
                    if (r_rx_cnt != '0) begin
                        r_rx_cnt <= r_rx_cnt - ONE;
                    end else begin
                        // Leaving at mid-stop so the next start edge is never missed.
                        r_rx_byte  <= r_rx_sh;
                        r_rx_push  <= 1'b1;
                        r_rx_ferr  <= ~r_rx_s2;
                        r_rx_state <= RX_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/wb_uart.md
Name: wb_uart

Overview:
- Parametrised hardware UART replacing the bit-bang UART on the icebreaker I/O bus.
- Wishbone classic slave with a programmable baud divisor, TX holding plus shift register, and RX deglitch/mid-bit sampling.
- Provides a 2^RXAW-deep RX FIFO and sticky error flags.
- Frees the midgetv core from software bit timing; sits on the IO decode alongside the LED block.

Parameters:
- DATABITS, 8: data bits per frame (5..9); LSB first, 1 start bit, 1 stop bit, no parity.
- DIVWIDTH, 16: width of the baud divisor register.
- DEFDIV, 104: divisor after reset (12 MHz / 115200).
- RXAW, 2: log2 of RX FIFO depth (depth 4 by default).

Ports:
- CLK_I  in  1  system clock.
- RST_I  in  1  reset, asynchronous, active-low.
- STB_I  in  1  Wishbone strobe, already qualified by address decode.
- WE_I  in  1  write enable.
- ADR_I  in  2  register select (word address bits [3:2]).
- DAT_I  in  32  write data.
- DAT_O  out  32  read data, registered.
- ACK_O  out  1  acknowledge, equal to STB_I (zero wait state).
- usartRX  in  1  serial input, asynchronous.
- usartTX  out  1  serial output, idles high.
- irq  out  1  level interrupt: (RX FIFO non-empty & rxie) | (TX holding empty & txie).

Behaviour:
- Clock and reset: one clock, CLK_I; RST_I is asynchronous and active-low.
- Reset values: usartTX=1, DAT_O=0, div=DEFDIV, FIFO empty, all flags 0, rxie=txie=0, both FSMs IDLE.
- Register map (ADR_I):
  - 0 DATA. Write pushes DAT_I[DATABITS-1:0] to the TX holding register. Read returns {valid at bit 31, rx byte at [DATABITS-1:0]} and pops one entry if non-empty. An empty read returns 0 and pops nothing.
  - 1 STATUS (read):
    - bit0 rxne; bit1 thre (holding empty); bit2 txidle (holding empty and shifter idle).
    - bit3 rxovr; bit4 ferr; bit5 txovr.
    - Write-1-to-clear on bits 3..5.
  - 2 DIV. Read/write div[DIVWIDTH-1:0]. Bit period = div clocks. Written values <4 are stored as 4.
  - 3 CTRL. bit0 rxie, bit1 txie. Bit 2 write-only: writing 1 flushes the RX FIFO; it always reads 0.
- Read timing: DAT_O is registered on STB_I & ~WE_I and is valid the cycle after ACK. The FIFO pop takes effect at that same edge.
- TX path:
  - A write to DATA while the holding register is full is dropped and sets txovr.
  - FSM IDLE -> START -> DATA(DATABITS bits) -> STOP -> IDLE, each state lasting div clocks, driven by a down-counter reloaded at each bit boundary.
  - Holding transfers to the shifter in IDLE one cycle after it becomes full.
  - On STOP exit, if holding is full, go directly to START (back-to-back frames, no idle gap).
  - A DIV write mid-frame takes effect at the next bit boundary.
- RX path:
  - 2-flop synchroniser on usartRX; all logic uses the synchronised value.
  - FSM IDLE -> START on a falling edge.
  - In START, sample after div/2 clocks (integer floor). If high, treat as a glitch and return to IDLE with nothing stored.
  - DATA samples every div clocks, LSB first.
  - STOP samples once. If low, set ferr and still store the byte.
  - After the STOP sample, go to IDLE immediately (half-bit early) so that the next falling edge is caught.
  - Store when FIFO is full: byte dropped, rxovr set, FIFO contents unchanged.
- Simultaneous events:
  - RX store and DATA-read pop in the same cycle: occupancy unchanged, order preserved.
  - RX store into a full FIFO in the same cycle as a pop: accepted, no overrun.
  - A W1C write in the same cycle as a new error event: the flag remains set.
- FIFO: pointers RXAW+1 bits wide, with wrap-around. full = MSBs differ and low bits equal.
- Reset mid-frame: usartTX returns high immediately (asynchronous). The partial RX frame is discarded.

Test Plan:
- Reset, then read DIV -> 104; STATUS -> 0x06 (thre=1, txidle=1); usartTX=1.
- DIV=8, write DATA 0xA5 -> usartTX low 8 clocks, then bits 1,0,1,0,0,1,0,1 at 8 clocks each, then high 8 clocks; txidle returns to 1 after 80 clocks.
- DIV=8, two back-to-back DATA writes 0x55, 0x0F, then a third while both are busy -> both frames sent with no idle gap; third write dropped; STATUS bit5 set; write STATUS 0x20 clears it.
- DIV=16, drive frames 0x31..0x35 into usartRX without reading -> first 4 stored, 5th sets rxovr. Reads return 0x80000031..0x80000034, then 0x00000000.
- DIV=16, a 3-clock low glitch on usartRX -> nothing stored, rxne stays 0. A frame with stop bit low carrying 0x7E -> byte 0x7E stored and ferr=1.
- rxie=1, receive 1 byte -> irq=1; read DATA -> irq=0. Assert RST_I=0 mid-TX-frame -> usartTX=1 the same cycle and all registers at reset values.
